// File: rtl/lsu.sv
// Load/store unit: one outstanding access, valid/ready request to data memory, extended load return.
// Optional abort-on-timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_signed_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                dmem_valid_o,
  input  logic                dmem_ready_i,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic                dmem_wen_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_wstrb_o,
  input  logic                dmem_rvalid_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q;
  logic [1:0]          off_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                dmem_valid_q;
  logic                dmem_wen_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic [STRB_W-1:0]   dmem_wstrb_q;

  logic                misaligned_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   shifted_d;
  logic [DATA_W-1:0]   load_data_d;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]          cnt_q;
  logic                tmo_hit_d;
  assign tmo_hit_d = (cnt_q == 8'(TIMEOUT));
`endif

  always_comb begin
    misaligned_d = 1'b0;
    wstrb_d      = '1;
    unique case (req_size_i)
      2'd0: wstrb_d = STRB_W'(1) << req_addr_i[1:0];
      2'd1: begin
        wstrb_d      = STRB_W'(3) << {req_addr_i[1], 1'b0};
        misaligned_d = req_addr_i[0];
      end
      2'd2: misaligned_d = (req_addr_i[1:0] != 2'b00);
      default: misaligned_d = 1'b1;
    endcase
  end

  // Replicate the store datum across every lane so memory can pick any byte/half by strobe.
  genvar gi;
  for (gi = 0; gi < STRB_W; gi++) begin : g_lane
    assign wdata_d[8*gi +: 8] = (req_size_i == 2'd0) ? req_wdata_i[7:0] :
                                (req_size_i == 2'd1) ? req_wdata_i[8*(gi%2) +: 8] :
                                                       req_wdata_i[8*gi +: 8];
  end

  assign shifted_d = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_data_d = {{(DATA_W-8){signed_q & shifted_d[7]}}, shifted_d[7:0]};
      2'd1:    load_data_d = {{(DATA_W-16){signed_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_data_d = shifted_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      dmem_valid_q <= 1'b0;
      dmem_wen_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
`endif
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            off_q       <= req_addr_i[1:0];
            size_q      <= req_size_i;
            signed_q    <= req_signed_i;
            req_ready_q <= 1'b0;
            if (misaligned_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q      <= S_REQ;
              dmem_valid_q <= 1'b1;
              dmem_wen_q   <= req_wen_i;
              dmem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              dmem_wstrb_q <= req_wen_i ? wstrb_d : '0;
              dmem_wdata_q <= req_wen_i ? wdata_d : '0;
`ifdef LSU_TIMEOUT_EN
              cnt_q        <= 8'd0;
`endif
            end
          end
        end
        S_REQ: begin
          if (dmem_ready_i) begin
            dmem_valid_q <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_wstrb_q <= '0;
            if (dmem_wen_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              state_q <= S_WAIT;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit_d) begin
            dmem_valid_q <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_wstrb_q <= '0;
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
`endif
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data_d;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit_d) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
`endif
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign dmem_valid_o = dmem_valid_q;
  assign dmem_wen_o   = dmem_wen_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_wstrb_o = dmem_wstrb_q;

endmodule
